if_pc_unit: RTL
===============

Name: if_pc_unit

Overview:
- IF-stage program-counter unit of the 5-stage MIPS pipeline.
- Holds the fetch PC and selects the next PC from these sources: sequential, branch, j/jal, jr/jalr, exception vector, and eret.
- Consumes the branch-comparator result from ID together with the ID-stage decode fields.
- Produces the fetch address, the delay-slot marker for the fetched instruction, and a fetch-address-error flag.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_BYTES, 32'h0000_2000, size of the legal fetch window in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit freeze of IF/ID.
- cmp_result  in  1  branch condition from the ID comparator, already decoded per branch type.
- id_is_branch  in  1  ID instruction is a conditional branch.
- id_is_jump  in  1  ID instruction is j or jal.
- id_is_jr  in  1  ID instruction is jr or jalr.
- id_pc  in  32  PC of the ID instruction.
- id_imm16  in  16  branch offset field.
- id_instr_index  in  26  jump index field.
- id_rs_val  in  32  forwarded rs value.
- exc_req  in  1  exception taken this cycle, from the CP0 stage.
- eret_req  in  1  eret committing this cycle.
- epc  in  32  return address for eret.
- pc  out  32  current fetch address.
- if_bd  out  1  fetched instruction is a delay slot.
- if_adel  out  1  fetch address error.
- redirect_cnt  out  32  count of taken control transfers.

Behaviour:
- Reset (asynchronous, any cycle, including mid-flush):
  - pc=RESET_PC, if_bd=0, redirect_cnt=0.
  - State=RUN.
  - if_adel is derived from pc, so it is 0 at reset with default parameters.
- Target arithmetic (all 32-bit, wrap-around ignored):
  - seq = pc+4.
  - btarget = id_pc + 4 + (sign_extend(id_imm16)<<2).
  - jtarget = {id_pc+4 [31:28], id_instr_index, 2'b00}.
  - jrtarget = id_rs_val, unmodified; misalignment is reported via if_adel on the next fetch.
- taken = (id_is_branch & cmp_result) | id_is_jump | id_is_jr, evaluated only in RUN. If more than one id_is_* is asserted, jr > jump > branch.
- Next-PC priority, registered on the rising clk:
  - exc_req → EXC_VEC, state→FLUSH.
  - else eret_req → epc, state→FLUSH.
  - else stall → pc held, if_bd held, no count.
  - else RUN & taken → selected target; redirect_cnt+1.
  - else seq.
- States:
  - RUN: normal operation.
  - FLUSH: exactly one cycle after exc/eret. id_* and cmp_result are ignored because ID holds a squashed instruction, so next=seq (or a new exc/eret) and no count. Return to RUN unconditionally next cycle.
- exc_req and stall in the same cycle: exc_req wins; the stall is ignored.
- if_bd:
  - Registered as 1 on any non-stalled RUN cycle where id_is_branch|id_is_jump|id_is_jr, regardless of whether the branch is taken.
  - 0 on exc/eret/FLUSH cycles.
  - Held when stalled.
- if_adel: combinational; 1 when pc[1:0]!=0 or pc<IMEM_BASE or pc>=IMEM_BASE+IMEM_BYTES. The PC still advances; the exception is raised downstream.
- redirect_cnt wraps 32'hFFFF_FFFF→0.
- Latency: a branch resolved in ID in cycle N appears on pc at N+1. The delay slot is fetched in cycle N.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC and EXC_VEC defaults.
  - The 2-bit pc_state enum {RUN, FLUSH}.
  - A 3-bit next-PC select enum {SEQ, BR, J, JR, EXC, ERET}.
- One natural sub-module: npc_calc, combinational, computing seq, btarget, jtarget and the select code. The PC register, FSM, if_bd and counter stay in if_pc_unit.

Test Plan:
- Reset → pc=0x3000, if_bd=0, redirect_cnt=0. Release reset, run 3 cycles without control → pc=0x3004, 0x3008, 0x300C.
- id_pc=0x3010, id_is_branch=1, cmp_result=1, imm16=0xFFFC → next pc=0x3004, redirect_cnt=1, if_bd=1. Repeat with cmp_result=0 → pc=seq, if_bd=1, count unchanged.
- id_is_jr=1, id_rs_val=0x3402 → pc=0x3402 and if_adel=1. Also check id_rs_val=0x5000 → if_adel=1 (out of window).
- stall=1 for 2 cycles with a taken branch in ID → pc and if_bd held, no count. Release → redirect to target.
- exc_req=1 concurrent with stall=1 and a taken jump → pc=0x4180. Next cycle (FLUSH) with id_is_jump=1 → pc=0x4184, no count. Then eret_req with epc=0x3020 → pc=0x3020.
- Assert reset asynchronously mid-FLUSH, between clock edges → pc=0x3000 immediately and state RUN on release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: reset/exception addresses,
// the PC-unit state encoding and the next-PC source select codes.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF    = 32'h0000_4180;
   localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
   localparam logic [31:0] IMEM_BYTES_DEF = 32'h0000_2000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1
   } pc_state_e;

   typedef enum logic [2:0] {
      SEQ  = 3'd0,
      BR   = 3'd1,
      J    = 3'd2,
      JR   = 3'd3,
      EXC  = 3'd4,
      ERET = 3'd5
   } npc_sel_e;

   function automatic logic [31:0] sext_shift2(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/if_pc_unit_npc_calc.sv
// Combinational next-PC calculation: computes the candidate targets and
// picks the source by exception > eret > jr > jump > taken branch > sequential.
module npc_calc
   import mips_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
   input  logic [31:0] pc,
   input  logic        in_run,
   input  logic        cmp_result,
   input  logic        id_is_branch,
   input  logic        id_is_jump,
   input  logic        id_is_jr,
   input  logic [31:0] id_pc,
   input  logic [15:0] id_imm16,
   input  logic [25:0] id_instr_index,
   input  logic [31:0] id_rs_val,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] npc,
   output npc_sel_e    sel
);

   logic [31:0] seq;
   logic [31:0] id_pc4;
   logic [31:0] btarget;
   logic [31:0] jtarget;

   assign seq     = pc + 32'd4;
   assign id_pc4  = id_pc + 32'd4;
   assign btarget = id_pc4 + sext_shift2(id_imm16);
   assign jtarget = {id_pc4[31:28], id_instr_index, 2'b00};

   // ID fields are only trusted in RUN; after a flush ID holds a squashed instruction
   always_comb begin
      sel = SEQ;
      npc = seq;
      if (exc_req) begin
         sel = EXC;
         npc = EXC_VEC;
      end else if (eret_req) begin
         sel = ERET;
         npc = epc;
      end else if (in_run && id_is_jr) begin
         sel = JR;
         npc = id_rs_val;
      end else if (in_run && id_is_jump) begin
         sel = J;
         npc = jtarget;
      end else if (in_run && id_is_branch && cmp_result) begin
         sel = BR;
         npc = btarget;
      end
   end

endmodule

// File: rtl/if_pc_unit.sv
// IF-stage program counter: holds the fetch PC, tracks the post-exception
// flush cycle, marks delay slots and counts taken control transfers.
module if_pc_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
   parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
   parameter logic [31:0] IMEM_BYTES = IMEM_BYTES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        cmp_result,
   input  logic        id_is_branch,
   input  logic        id_is_jump,
   input  logic        id_is_jr,
   input  logic [31:0] id_pc,
   input  logic [15:0] id_imm16,
   input  logic [25:0] id_instr_index,
   input  logic [31:0] id_rs_val,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc,
   output logic        if_bd,
   output logic        if_adel,
   output logic [31:0] redirect_cnt
);

   localparam logic [31:0] IMEM_END = IMEM_BASE + IMEM_BYTES;

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        bd_q, bd_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] npc;
   npc_sel_e    sel;
   logic        in_run;

   assign in_run = (state_q == RUN);

   npc_calc #(
      .EXC_VEC(EXC_VEC)
   ) u_npc_calc (
      .pc             (pc_q),
      .in_run         (in_run),
      .cmp_result     (cmp_result),
      .id_is_branch   (id_is_branch),
      .id_is_jump     (id_is_jump),
      .id_is_jr       (id_is_jr),
      .id_pc          (id_pc),
      .id_imm16       (id_imm16),
      .id_instr_index (id_instr_index),
      .id_rs_val      (id_rs_val),
      .exc_req        (exc_req),
      .eret_req       (eret_req),
      .epc            (epc),
      .npc            (npc),
      .sel            (sel)
   );

   // exc/eret override a stall; FLUSH always lasts one cycle even if stalled
   always_comb begin
      state_d = RUN;
      pc_d    = pc_q;
      bd_d    = bd_q;
      cnt_d   = cnt_q;
      if (exc_req || eret_req) begin
         state_d = FLUSH;
         pc_d    = npc;
         bd_d    = 1'b0;
      end else if (!stall) begin
         pc_d = npc;
         bd_d = in_run && (id_is_branch || id_is_jump || id_is_jr);
         if (sel == BR || sel == J || sel == JR) begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         bd_q    <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         bd_q    <= bd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc           = pc_q;
   assign if_bd        = bd_q;
   assign redirect_cnt = cnt_q;
   assign if_adel      = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || (pc_q >= IMEM_END);

endmodule
